spwtcr_link_fsm_array: RTL

SPWTCR_LINK_FSM_ARRAY -- requirements
Module: spwtcr_link_fsm_array

---
 rtl/spwtcr_link_fsm_array_pkg.sv | 12 +
 rtl/spwtcr_link_fsm_core.sv | 96 +++++++++
 rtl/spwtcr_link_fsm_array.sv | 68 ++++++
 3 files changed

// File: rtl/spwtcr_link_fsm_array_pkg.sv
// spwtcr_pkg: link state encoding shared by the SpaceWire link FSM array.
package spwtcr_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        ERROR_RESET = 3'b000,
        ERROR_WAIT  = 3'b001,
        READY       = 3'b011,
        STARTED     = 3'b010,
        CONNECTING  = 3'b100,
        RUN         = 3'b101
    } linkState_t;
endpackage

// File: rtl/spwtcr_link_fsm_core.sv
// spwtcr_link_fsm_core: one SpaceWire link init FSM with its own timer;
// per-link error counter present only when SPWTCR_ERRCNT_EN is defined.
module spwtcr_link_fsm_core
    import spwtcr_pkg::*;
#(
    parameter int T64_CYCLES  = 64,
    parameter int T128_CYCLES = 128
) (
    input  logic       CLOCK,
    input  logic       RESETn,
    input  logic       linkStart,
    input  logic       linkDisable,
    input  logic       autoStart,
    input  logic       gotNULL,
    input  logic       gotFCT,
    input  logic       gotNChar,
    input  logic       gotTimeCode,
    input  logic       rxError,
    input  logic       creditError,
`ifdef SPWTCR_ERRCNT_EN
    input  logic       errCntClr,
    output logic [7:0] errCnt,
`endif
    output logic [2:0] currentState,
    output logic       enableTx,
    output logic       enableRx,
    output logic       sendNULLs,
    output logic       sendFCTs,
    output logic       sendNChars,
    output logic       sendTimeCodes,
    output logic       resetTx,
    output logic       resetRx,
    output logic       startupRate
);
    localparam int TW = $clog2(T128_CYCLES + 1);

    linkState_t state, nextState;
    logic [TW-1:0] timer;
    logic firstCycle, after64, after128, counting, waitErr;

    assign after64  = timer == TW'(T64_CYCLES - 1);
    assign after128 = timer == TW'(T128_CYCLES - 1);
    assign counting = state inside {ERROR_RESET, ERROR_WAIT, STARTED, CONNECTING};
    assign waitErr  = rxError | (gotNULL & (gotFCT | gotNChar | gotTimeCode));

    always_comb begin
        nextState = state;
        case (state)
            ERROR_RESET: nextState = after64 ? ERROR_WAIT : ERROR_RESET;
            ERROR_WAIT:  nextState = after128 ? READY : waitErr ? ERROR_RESET : ERROR_WAIT;
            READY:       nextState = ((linkStart | (autoStart & gotNULL)) & !linkDisable) ? STARTED :
                                     waitErr ? ERROR_RESET : READY;
            STARTED:     nextState = gotNULL ? CONNECTING :
                                     (rxError | gotFCT | gotNChar | gotTimeCode | after128) ? ERROR_RESET : STARTED;
            CONNECTING:  nextState = gotFCT ? RUN :
                                     (rxError | gotNChar | gotTimeCode | after128) ? ERROR_RESET : CONNECTING;
            RUN:         nextState = (rxError | creditError | linkDisable) ? ERROR_RESET : RUN;
            default:     nextState = ERROR_RESET;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= ERROR_RESET;
            timer      <= '0;
            firstCycle <= 1'b1;
        end else begin
            state      <= nextState;
            firstCycle <= nextState != state;
            timer      <= (nextState != state || !counting) ? '0 : timer + TW'(1);
        end
    end

`ifdef SPWTCR_ERRCNT_EN
    // Only link-level errors seen in RUN count; a deliberate disable does not.
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn)
            errCnt <= '0;
        else if (errCntClr)
            errCnt <= '0;
        else if (state == RUN && (rxError | creditError) && errCnt != 8'hFF)
            errCnt <= errCnt + 8'd1;
    end
`endif

    assign currentState  = state;
    assign enableTx      = state inside {STARTED, CONNECTING, RUN};
    assign enableRx      = state inside {ERROR_WAIT, READY, STARTED, CONNECTING, RUN};
    assign sendNULLs     = enableTx;
    assign sendFCTs      = state inside {CONNECTING, RUN};
    assign sendNChars    = state == RUN;
    assign sendTimeCodes = state == RUN;
    assign resetTx       = !(firstCycle && state inside {ERROR_RESET, ERROR_WAIT, READY});
    assign resetRx       = !(firstCycle && state == ERROR_RESET);
    assign startupRate   = state != RUN;
endmodule

// File: rtl/spwtcr_link_fsm_array.sv
// spwtcr_link_fsm_array: N_LINKS independent SpaceWire link FSMs;
// ERRCNT/ERRCNT_CLR exist only when SPWTCR_ERRCNT_EN is defined.
module spwtcr_link_fsm_array
    import spwtcr_pkg::*;
#(
    parameter int N_LINKS     = 4,
    parameter int T64_CYCLES  = 64,
    parameter int T128_CYCLES = 128
) (
    input  logic                   CLOCK,
    input  logic                   RESETn,
    input  logic [N_LINKS-1:0]     LINK_START,
    input  logic [N_LINKS-1:0]     LINK_DISABLE,
    input  logic [N_LINKS-1:0]     AUTOSTART,
    input  logic [N_LINKS-1:0]     gotNULL,
    input  logic [N_LINKS-1:0]     gotFCT,
    input  logic [N_LINKS-1:0]     gotNChar,
    input  logic [N_LINKS-1:0]     gotTimeCode,
    input  logic [N_LINKS-1:0]     rxError,
    input  logic [N_LINKS-1:0]     creditError,
`ifdef SPWTCR_ERRCNT_EN
    input  logic [N_LINKS-1:0]     ERRCNT_CLR,
    output logic [8*N_LINKS-1:0]   ERRCNT,
`endif
    output logic [3*N_LINKS-1:0]   CURRENTSTATE,
    output logic [N_LINKS-1:0]     enableTx,
    output logic [N_LINKS-1:0]     enableRx,
    output logic [N_LINKS-1:0]     sendNULLs,
    output logic [N_LINKS-1:0]     sendFCTs,
    output logic [N_LINKS-1:0]     sendNChars,
    output logic [N_LINKS-1:0]     sendTimeCodes,
    output logic [N_LINKS-1:0]     resetTx,
    output logic [N_LINKS-1:0]     resetRx,
    output logic [N_LINKS-1:0]     startupRate
);
    for (genvar i = 0; i < N_LINKS; i++) begin : gLink
        spwtcr_link_fsm_core #(
            .T64_CYCLES (T64_CYCLES),
            .T128_CYCLES(T128_CYCLES)
        ) uCore (
            .CLOCK        (CLOCK),
            .RESETn       (RESETn),
            .linkStart    (LINK_START[i]),
            .linkDisable  (LINK_DISABLE[i]),
            .autoStart    (AUTOSTART[i]),
            .gotNULL      (gotNULL[i]),
            .gotFCT       (gotFCT[i]),
            .gotNChar     (gotNChar[i]),
            .gotTimeCode  (gotTimeCode[i]),
            .rxError      (rxError[i]),
            .creditError  (creditError[i]),
`ifdef SPWTCR_ERRCNT_EN
            .errCntClr    (ERRCNT_CLR[i]),
            .errCnt       (ERRCNT[8*i +: 8]),
`endif
            .currentState (CURRENTSTATE[3*i +: 3]),
            .enableTx     (enableTx[i]),
            .enableRx     (enableRx[i]),
            .sendNULLs    (sendNULLs[i]),
            .sendFCTs     (sendFCTs[i]),
            .sendNChars   (sendNChars[i]),
            .sendTimeCodes(sendTimeCodes[i]),
            .resetTx      (resetTx[i]),
            .resetRx      (resetRx[i]),
            .startupRate  (startupRate[i])
        );
    end
endmodule
